// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
// serial_sub_pkg : shared FSM state type and counter sizing helper for the
//                  bit-serial subtractor.  Rev 1.0
// ============================================================================
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit counter must index stages 0..w-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_subtractor_full_subtractor.sv
`default_nettype none
// ============================================================================
// full_subtractor : one-bit combinational subtractor cell (a - b - bin).
//                   Rev 1.0
// ============================================================================
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// serial_subtractor : LSB-first bit-serial unsigned a - b with valid/ready
//                     handshakes. Optional SERIAL_SUB_SAT_EN clamps diff to 0
//                     when the result borrows.  Rev 1.0
// ============================================================================
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] diff,
    output logic [DATA_WIDTH-1:0] borrow_int,
    output logic                  borrow_out
);

    localparam int              CNT_W  = cnt_width(DATA_WIDTH);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DATA_WIDTH - 1);

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [DATA_WIDTH-1:0]   b_sh_q, b_sh_d;
    logic                    brw_q, brw_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   diff_q, diff_d;
    logic [DATA_WIDTH-1:0]   bint_q, bint_d;
    logic                    bout_q, bout_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;

    logic                    w_step_diff;
    logic                    w_step_borrow;

    full_subtractor u_fs (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (brw_q),
        .d    (w_step_diff),
        .bout (w_step_borrow)
    );

    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        brw_d       = brw_q;
        cnt_d       = cnt_q;
        diff_d      = diff_q;
        bint_d      = bint_q;
        bout_d      = bout_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_sh_d     = a;
                    b_sh_d     = b;
                    brw_d      = 1'b0;
                    cnt_d      = '0;
                    diff_d     = '0;
                    bint_d     = '0;
                    bout_d     = 1'b0;
                    in_ready_d = 1'b0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                // Result bits enter at the MSB so the word is aligned after the last step.
                diff_d         = {w_step_diff, diff_q[DATA_WIDTH-1:1]};
                bint_d[cnt_q]  = w_step_borrow;
                brw_d          = w_step_borrow;
                a_sh_d         = a_sh_q >> 1;
                b_sh_d         = b_sh_q >> 1;
                if (cnt_q == C_LAST) begin
                    bout_d      = w_step_borrow;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
`ifdef SERIAL_SUB_SAT_EN
                    if (w_step_borrow) begin
                        diff_d = '0;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            brw_q       <= 1'b0;
            cnt_q       <= '0;
            diff_q      <= '0;
            bint_q      <= '0;
            bout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            brw_q       <= brw_d;
            cnt_q       <= cnt_d;
            diff_q      <= diff_d;
            bint_q      <= bint_d;
            bout_q      <= bout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign diff       = diff_q;
    assign borrow_int = bint_q;
    assign borrow_out = bout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// tb_serial_subtractor : self-checking bench for serial_subtractor at widths
//                        8 and 2; honours SERIAL_SUB_SAT_EN.  Rev 1.0
// ============================================================================
module tb_serial_subtractor;

    localparam int W  = 8;
    localparam int W2 = 2;
`ifdef SERIAL_SUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          resetn;
    logic          in_valid, out_ready;
    logic [W-1:0]  a, b;
    logic          in_ready, out_valid, borrow_out;
    logic [W-1:0]  diff, borrow_int;

    logic          in_valid2, out_ready2;
    logic [W2-1:0] a2, b2;
    logic          in_ready2, out_valid2, borrow_out2;
    logic [W2-1:0] diff2, borrow_int2;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.DATA_WIDTH(W)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .borrow_int(borrow_int), .borrow_out(borrow_out)
    );

    serial_subtractor #(.DATA_WIDTH(W2)) dut2 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .out_valid(out_valid2), .out_ready(out_ready2),
        .diff(diff2), .borrow_int(borrow_int2), .borrow_out(borrow_out2)
    );

    typedef struct {
        int a;
        int b;
        int diff;
        int bint;
        int bout;
    } vec_t;

    vec_t tbl[8];

    // Reference: wrapped difference, optionally clamped when a < b.
    function automatic int model_diff(input int w, input int av, input int bv);
        int r;
        r = (av - bv) & ((1 << w) - 1);
        if (SAT && (av < bv)) r = 0;
        return r;
    endfunction

    // Stage i borrows out exactly when the low i+1 bits of a are below those of b.
    function automatic int model_bint(input int w, input int av, input int bv);
        int r;
        int m;
        r = 0;
        for (int i = 0; i < w; i++) begin
            m = (1 << (i + 1)) - 1;
            if ((av & m) < (bv & m)) r = r | (1 << i);
        end
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic run8(input int av, input int bv, input int ed, input int eb,
                        input int eo, input int stall, input bit preload);
        int  n;
        bit  seen;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready before op", int'(in_ready), 1);
        a = W'(av); b = W'(bv); in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom);
        check("in_ready after accept", int'(in_ready), 0);
        seen = 1'b0;
        for (n = 1; n <= W + 4; n++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("latency", seen ? n : -1, W);
        check("diff", int'(diff), ed);
        check("borrow_int", int'(borrow_int), eb);
        check("borrow_out", int'(borrow_out), eo);
        if (preload) begin
            a = W'(9); b = W'(4); in_valid = 1'b1;
        end
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            check("hold out_valid", int'(out_valid), 1);
            check("hold in_ready", int'(in_ready), 0);
            check("hold diff", int'(diff), ed);
            check("hold borrow", int'({borrow_out, borrow_int}), (eo << W) | eb);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid after handshake", int'(out_valid), 0);
        check("in_ready after handshake", int'(in_ready), 1);
    endtask

    task automatic run2(input int av, input int bv);
        int n;
        bit seen;
        n = 0;
        while (!in_ready2 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        a2 = W2'(av); b2 = W2'(bv); in_valid2 = 1'b1; out_ready2 = 1'b1;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        seen = 1'b0;
        for (n = 1; n <= W2 + 4; n++) begin
            @(posedge clk); #1;
            if (out_valid2) begin
                seen = 1'b1;
                break;
            end
        end
        check("w2 latency", seen ? n : -1, W2);
        check("w2 diff", int'(diff2), model_diff(W2, av, bv));
        check("w2 borrow_int", int'(borrow_int2), model_bint(W2, av, bv));
        check("w2 borrow_out", int'(borrow_out2), (av < bv) ? 1 : 0);
        @(posedge clk); #1;
        out_ready2 = 1'b0;
    endtask

    initial begin
        int ra, rb;
        tbl[0] = '{200, 55, 145, 'h37, 0};
        tbl[1] = '{5, 10, 251, 'hFA, 1};
        tbl[2] = '{255, 255, 0, 'h00, 0};
        tbl[3] = '{0, 0, 0, 'h00, 0};
        tbl[4] = '{0, 255, 1, 'hFF, 1};
        tbl[5] = '{100, 1, 99, 'h03, 0};
        tbl[6] = '{128, 1, 127, 'h7F, 0};
        tbl[7] = '{1, 2, 255, 'hFE, 1};

        resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        in_valid2 = 1'b0; out_ready2 = 1'b0; a2 = '0; b2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", int'(in_ready), 1);
        check("reset out_valid", int'(out_valid), 0);
        check("reset outputs", int'({diff, borrow_int, borrow_out}), 0);
        resetn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            run8(tbl[i].a, tbl[i].b,
                 (SAT && tbl[i].bout == 1) ? 0 : tbl[i].diff,
                 tbl[i].bint, tbl[i].bout, 0, 1'b0);
        end

        // Backpressure with the next operands already waiting.
        run8(30, 7, 23, model_bint(W, 30, 7), 0, 20, 1'b1);
        run8(9, 4, 5, model_bint(W, 9, 4), 0, 0, 1'b0);

        // Abort mid-operation with an asynchronous reset.
        a = W'(77); b = W'(3); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("async reset out_valid", int'(out_valid), 0);
        check("async reset diff", int'(diff), 0);
        check("async reset borrows", int'({borrow_int, borrow_out}), 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        check("in_ready after release", int'(in_ready), 1);
        check("no stale out_valid", int'(out_valid), 0);
        run8(100, 1, 99, 'h03, 0, 0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            ra = int'($urandom_range(255, 0));
            rb = int'($urandom_range(255, 0));
            run8(ra, rb, model_diff(W, ra, rb), model_bint(W, ra, rb),
                 (ra < rb) ? 1 : 0, 0, 1'b0);
        end

        for (int i = 0; i < 64; i++) begin
            ra = int'($urandom_range(3, 0));
            rb = int'($urandom_range(3, 0));
            run2(ra, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
